// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: data width, state encodings and the baud divisor macro.
// The RX stage reuses UART_BAUD_DIV so both directions agree on bit timing.
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

`ifndef UART_BAUD_DIV
`define UART_BAUD_DIV(clk_hz, baud) ((clk_hz) / (baud))
`endif

package uart_tx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// Bit-period divisor: counts 0..P_DIV-1 while enabled and flags the last count.
// Clearing on accept phase-locks the bit grid to the accept edge.
module uart_baud_tick
  import uart_tx_serializer_pkg::*;
#(
  parameter int P_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = cnt_width(P_DIV);
  localparam logic [CW-1:0] LAST = CW'(P_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, data LSB first, optional parity, stop bit(s).
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
//   state  | meaning
//   IDLE   | line high, ready high, waiting for valid
//   START  | start bit (0) on the line
//   DATA   | data bits, LSB first
//   PARITY | parity bit (only with UART_TX_PARITY_EN)
//   STOP   | stop bit(s), line high
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int P_CLK_FREQ   = 50_000_000,
  parameter int P_BAUD_RATE  = 115200,
  parameter int P_DATA_WIDTH = `UART_DATA_WIDTH,
  parameter int P_STOP_BITS  = 1,
  parameter int P_PARITY_ODD = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_user_tx_valid,
  input  logic [P_DATA_WIDTH-1:0] i_user_tx_data,
  output logic                    o_user_tx_ready,
  output logic                    o_uart_txd,
  output logic                    o_tx_busy
);

  localparam int DIV = `UART_BAUD_DIV(P_CLK_FREQ, P_BAUD_RATE);
  localparam int BCW = cnt_width(max_int(P_DATA_WIDTH, P_STOP_BITS));
  localparam logic [BCW-1:0] LAST_DATA = BCW'(P_DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(P_STOP_BITS - 1);

  generate
    if (DIV < 2 || P_STOP_BITS < 1 || P_STOP_BITS > 2 ||
        P_PARITY_ODD < 0 || P_PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_tx_serializer: illegal divisor, stop-bit or parity configuration");
    end
  endgenerate

  tx_state_e               state_q;
  logic [BCW-1:0]          bit_cnt_q;
  logic [P_DATA_WIDTH-1:0] shift_q;
  logic                    txd_q;
  logic                    ready_q;
  logic                    busy_q;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q;
`endif

  logic accept;
  logic baud_tick;
  logic baud_en;
  logic baud_clr;

  assign accept   = (state_q == ST_IDLE) && ready_q && i_user_tx_valid;
  assign baud_en  = (state_q != ST_IDLE);
  assign baud_clr = accept;

  uart_baud_tick #(
    .P_DIV (DIV)
  ) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (baud_clr),
    .i_en   (baud_en),
    .o_tick (baud_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q   <= ST_START;
            shift_q   <= i_user_tx_data;
            bit_cnt_q <= '0;
            txd_q     <= LINE_START;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^i_user_tx_data) ^ P_PARITY_ODD[0];
`endif
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state_q   <= ST_DATA;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= ST_PARITY;
              txd_q     <= parity_q;
`else
              state_q   <= ST_STOP;
              txd_q     <= LINE_IDLE;
`endif
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            state_q   <= ST_STOP;
            txd_q     <= LINE_IDLE;
            bit_cnt_q <= '0;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_q   <= ST_IDLE;
              bit_cnt_q <= '0;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
          txd_q     <= LINE_IDLE;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_uart_txd      = txd_q;
  assign o_user_tx_ready = ready_q;
  assign o_tx_busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at DIV=4, 8 data bits, 1 stop bit.
// Parity vectors run only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serializer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       txd;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_serializer #(
    .P_CLK_FREQ   (400),
    .P_BAUD_RATE  (100),
    .P_DATA_WIDTH (8),
    .P_STOP_BITS  (1),
    .P_PARITY_ODD (0)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_user_tx_valid (valid),
    .i_user_tx_data  (data),
    .o_user_tx_ready (ready),
    .o_uart_txd      (txd),
    .o_tx_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // line[i] is the hand-derived level of bit-time i ('0'/'1'), start bit first.
  task automatic run_frame(input string tag, input logic [7:0] d, input string line,
                           input int mid_cyc, input logic [7:0] mid_d, input bit keep_valid);
    int ncyc;
    logic exp_bit;
    ncyc  = line.len() * DIV;
    valid = 1'b1;
    data  = d;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (c == mid_cyc) data = mid_d;
      exp_bit = (line[c / DIV] == "1");
      chk($sformatf("%s txd c%0d", tag, c), {31'd0, txd}, {31'd0, exp_bit});
      chk($sformatf("%s rdy/busy c%0d", tag, c), {30'd0, ready, busy}, 32'd1);
    end
    step();
    chk($sformatf("%s end txd/rdy/busy", tag), {29'd0, txd, ready, busy}, 32'd6);
    if (!keep_valid) valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held 3 cycles, then 20 quiet idle cycles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset c%0d", i), {29'd0, txd, ready, busy}, 32'd6);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle c%0d", i), {29'd0, txd, ready, busy}, 32'd6);
    end

    run_frame("f55", 8'h55, "0101010101", -1, 8'h00, 1'b0);
    step();
    chk("gap after f55", {29'd0, txd, ready, busy}, 32'd6);

    // Data changes to 0xFF mid-frame; line must still carry 0xA3.
    run_frame("fA3", 8'hA3, "0110001011", 10, 8'hFF, 1'b0);
    step();

    // Valid held across both frames: exactly one idle cycle between them.
    run_frame("b2b01", 8'h01, "0100000001", -1, 8'h00, 1'b1);
    run_frame("b2b80", 8'h80, "0000000011", -1, 8'h00, 1'b0);
    step();
    chk("idle after b2b", {29'd0, txd, ready, busy}, 32'd6);

    // Reset asserted 15 cycles into a 0x00 frame.
    valid = 1'b1;
    data  = 8'h00;
    for (int c = 0; c < 15; c++) begin
      step();
      chk($sformatf("pre-rst c%0d", c), {29'd0, txd, ready, busy}, 32'd1);
    end
    rst   = 1'b1;
    valid = 1'b0;
    step();
    chk("mid-frame reset", {29'd0, txd, ready, busy}, 32'd6);
    rst = 1'b0;
    step();
    chk("post-reset idle", {29'd0, txd, ready, busy}, 32'd6);
    run_frame("f00", 8'h00, "0000000001", -1, 8'h00, 1'b0);
    step();

`ifdef UART_TX_PARITY_EN
    run_frame("par07", 8'h07, "01110000011", -1, 8'h00, 1'b0);
    step();
    run_frame("par03", 8'h03, "01100000001", -1, 8'h00, 1'b0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
